td4_core_param: RTL and testbench

- Parametrised TD4-class CPU core with an integrated run/step controller.
- Widens the 4-bit TD4 datapath to DW bits and the 4-bit PC to AW bits.
- Adds a free-run / single-step mode input and a fetch/execute sequencer that tolerates a 1-cycle-latency synchronous ROM.
- Sits between the board top (switches, 7-seg decoders) and a program ROM; replaces the fixed core plus external 1 Hz enable.

---
 rtl/td4_pkg.sv | 23 ++
 rtl/td4_tick_gen.sv | 56 +++++
 rtl/td4_core_param.sv | 147 ++++++++++++++
 tb/tb_td4_core_param.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared opcode and sequencer-state definitions for the parametrised TD4 core.
package td4_pkg;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_IM = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/td4_tick_gen.sv
// Instruction tick source: CLK/DIV divider in run mode, debounced-free
// synchronised STEP rising edge in single-step mode. Emits one-cycle ticks.
module td4_tick_gen
    import td4_pkg::*;
#(
    parameter int DIV = 50000000
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic run,
    input  logic step,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic          run_s1;
    logic          run_s2;
    logic          step_s1;
    logic          step_s2;
    logic          step_d;
    logic [CW-1:0] div_cnt;

    // Two-flop synchronisers for RUN and STEP, plus the STEP edge-detect flop
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            run_s1  <= 1'b0;
            run_s2  <= 1'b0;
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
            step_d  <= 1'b0;
        end else begin
            run_s1  <= run;
            run_s2  <= run_s1;
            step_s1 <= step;
            step_s2 <= step_s1;
            step_d  <= step_s2;
        end
    end

    // Divider parks at 0 in step mode so a new run always starts a full period
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!run_s2) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign tick = run_s2 ? (div_cnt == DIV_LAST) : (step_s2 & ~step_d);

endmodule

// File: rtl/td4_core_param.sv
// Parametrised TD4-class core: DW-bit datapath, AW-bit PC, run/step sequencer
// that tolerates a one-cycle-latency synchronous program ROM.
//
// state | meaning
// IDLE  | waiting for a tick; ticks here start an instruction
// FETCH | ADDR=PC already stable, ROM output settling
// EXEC  | ROM_DATA decoded; registers, PC, DONE commit at the end of this cycle
module td4_core_param
    import td4_pkg::*;
#(
    parameter int DW  = 4,
    parameter int AW  = 4,
    parameter int DIV = 50000000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RUN,
    input  logic          STEP,
    input  logic [DW-1:0] IN,
    input  logic [DW+3:0] ROM_DATA,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] OUT,
    output logic          CARRY,
    output logic          DONE,
    output logic          ILLEGAL
);
    state_t        state;
    state_t        state_nxt;
    logic          tick;

    logic [DW-1:0] reg_a;
    logic [DW-1:0] reg_b;
    logic [DW-1:0] reg_out;
    logic          carry_r;
    logic [AW-1:0] pc;

    logic [DW-1:0] a_nxt;
    logic [DW-1:0] b_nxt;
    logic [DW-1:0] out_nxt;
    logic          carry_nxt;
    logic [AW-1:0] pc_nxt;
    logic          illegal_nxt;

    logic [3:0]    op;
    logic [DW-1:0] im;
    logic [DW:0]   sum_a;
    logic [DW:0]   sum_b;
    logic [AW-1:0] jmp_target;

    td4_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk_sys(CLK),
        .rst    (RST),
        .run    (RUN),
        .step   (STEP),
        .tick   (tick)
    );

    assign op         = ROM_DATA[DW+3:DW];
    assign im         = ROM_DATA[DW-1:0];
    assign sum_a      = {1'b0, reg_a} + {1'b0, im};
    assign sum_b      = {1'b0, reg_b} + {1'b0, im};
    assign jmp_target = AW'(im);

    // Sequencer state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: ticks outside IDLE are simply ignored, never queued
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = FETCH;
            FETCH:   state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Instruction decode; any non-ADD clears carry, JNC reads it first
    always_comb begin
        a_nxt       = reg_a;
        b_nxt       = reg_b;
        out_nxt     = reg_out;
        carry_nxt   = 1'b0;
        pc_nxt      = pc + AW'(1);
        illegal_nxt = 1'b0;
        case (op)
            OP_ADD_A: begin
                a_nxt     = sum_a[DW-1:0];
                carry_nxt = sum_a[DW];
            end
            OP_MOV_AB: a_nxt = reg_b;
            OP_IN_A:   a_nxt = IN;
            OP_MOV_A:  a_nxt = im;
            OP_MOV_BA: b_nxt = reg_a;
            OP_ADD_B: begin
                b_nxt     = sum_b[DW-1:0];
                carry_nxt = sum_b[DW];
            end
            OP_IN_B:   b_nxt   = IN;
            OP_MOV_B:  b_nxt   = im;
            OP_OUT_B:  out_nxt = reg_b;
            OP_OUT_IM: out_nxt = im;
            OP_JNC:    if (!carry_r) pc_nxt = jmp_target;
            OP_JMP:    pc_nxt = jmp_target;
            default:   illegal_nxt = 1'b1;
        endcase
    end

    // Architectural state commits only at the end of EXEC, so a reset
    // during FETCH/EXEC leaves nothing half-written
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            reg_a   <= '0;
            reg_b   <= '0;
            reg_out <= '0;
            carry_r <= 1'b0;
            pc      <= '0;
            DONE    <= 1'b0;
            ILLEGAL <= 1'b0;
        end else begin
            DONE    <= 1'b0;
            ILLEGAL <= 1'b0;
            if (state == EXEC) begin
                reg_a   <= a_nxt;
                reg_b   <= b_nxt;
                reg_out <= out_nxt;
                carry_r <= carry_nxt;
                pc      <= pc_nxt;
                DONE    <= 1'b1;
                ILLEGAL <= illegal_nxt;
            end
        end
    end

    assign ADDR  = pc;
    assign OUT   = reg_out;
    assign CARRY = carry_r;

endmodule

// File: tb/tb_td4_core_param.sv
// Bench for td4_core_param: main instance at DW=4/AW=4/DIV=4, plus a DW=8
// instance for jump-target truncation.
module tb_td4_core_param;
    localparam int DW   = 4;
    localparam int AW   = 4;
    localparam int DIV  = 4;
    localparam int DMOD = 1 << DW;
    localparam int PMOD = 1 << AW;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          run     = 1'b0;
    logic          step    = 1'b0;
    logic [DW-1:0] in_port = '0;
    logic [DW+3:0] rom [PMOD];
    logic [DW+3:0] rom_q   = '0;
    logic [AW-1:0] addr;
    logic [DW-1:0] out_port;
    logic          carry;
    logic          done;
    logic          illegal;

    logic          rst8  = 1'b0;
    logic          run8  = 1'b0;
    logic          step8 = 1'b0;
    logic [7:0]    in8   = 8'h00;
    logic [11:0]   rom8 [16];
    logic [11:0]   rom8_q = '0;
    logic [3:0]    addr8;
    logic [7:0]    out8;
    logic          carry8;
    logic          done8;
    logic          illegal8;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    bit dut8_fin = 1'b0;

    int done_seen   = 0;
    int ill_at_done = 0;
    int done_next   = 0;
    int ill_next    = 0;

    // reference model state
    int m_a = 0, m_b = 0, m_out = 0, m_c = 0, m_pc = 0, m_done = 0, m_ill = 0;
    int streak = 0, pend = 0;
    bit h_run [3];
    bit h_step [3];

    always #5 clk = ~clk;

    always @(posedge clk) rom_q  <= rom[addr];
    always @(posedge clk) rom8_q <= rom8[addr8];

    td4_core_param #(.DW(DW), .AW(AW), .DIV(DIV)) dut (
        .CLK(clk), .RST(rst), .RUN(run), .STEP(step), .IN(in_port),
        .ROM_DATA(rom_q), .ADDR(addr), .OUT(out_port), .CARRY(carry),
        .DONE(done), .ILLEGAL(illegal)
    );

    td4_core_param #(.DW(8), .AW(4), .DIV(4)) dut8 (
        .CLK(clk), .RST(rst8), .RUN(run8), .STEP(step8), .IN(in8),
        .ROM_DATA(rom8_q), .ADDR(addr8), .OUT(out8), .CARRY(carry8),
        .DONE(done8), .ILLEGAL(illegal8)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // executes the instruction at the model PC from the ISA rules
    task automatic model_retire();
        int word, op, im, nxt_pc, c_new;
        word   = int'(rom[m_pc]);
        op     = word / DMOD;
        im     = word % DMOD;
        nxt_pc = (m_pc + 1) % PMOD;
        c_new  = 0;
        m_ill  = 0;
        case (op)
            0:  begin c_new = (m_a + im >= DMOD) ? 1 : 0; m_a = (m_a + im) % DMOD; end
            1:  m_a = m_b;
            2:  m_a = int'(in_port);
            3:  m_a = im;
            4:  m_b = m_a;
            5:  begin c_new = (m_b + im >= DMOD) ? 1 : 0; m_b = (m_b + im) % DMOD; end
            6:  m_b = int'(in_port);
            7:  m_b = im;
            9:  m_out = m_b;
            11: m_out = im;
            14: if (m_c == 0) nxt_pc = im % PMOD;
            15: nxt_pc = im % PMOD;
            default: m_ill = 1;
        endcase
        m_c    = c_new;
        m_pc   = nxt_pc;
        m_done = 1;
    endtask

    // model timing: inputs pass 2 sync stages; an accepted tick retires 3 cycles later
    always @(posedge clk or posedge rst) begin
        bit tk;
        if (rst) begin
            m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_pc = 0; m_done = 0; m_ill = 0;
            streak = 0; pend = 0;
            for (int i = 0; i < 3; i++) begin h_run[i] = 1'b0; h_step[i] = 1'b0; end
        end else begin
            m_done = 0;
            m_ill  = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) model_retire();
            end
            if (h_run[1]) streak++;
            else streak = 0;
            h_run[2]  = h_run[1];  h_run[1]  = h_run[0];  h_run[0]  = run;
            h_step[2] = h_step[1]; h_step[1] = h_step[0]; h_step[0] = step;
            if (h_run[1]) tk = ((streak % DIV) == DIV - 1);
            else          tk = h_step[1] && !h_step[2];
            if (tk && pend == 0) pend = 3;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("addr",    int'(addr),     m_pc);
            check("out",     int'(out_port), m_out);
            check("carry",   int'(carry),    m_c);
            check("done",    int'(done),     m_done);
            check("illegal", int'(illegal),  m_ill);
        end
    end

    task automatic hold_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        run  = 1'b0;
        step = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < PMOD; i++) rom[i] = '0;
    endtask

    task automatic do_step();
        int k;
        bit seen;
        k    = 0;
        seen = 1'b0;
        step = 1'b1;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (done) begin
                seen = 1'b1;
                done_seen++;
                ill_at_done = int'(illegal);
            end
        end
        check("step_latency", k, 5);
        step = 1'b0;
        @(negedge clk);
        done_next = int'(done);
        ill_next  = int'(illegal);
        if (done) done_seen++;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
    endtask

    initial begin
        int k, cnt;
        clear_rom();
        #1 rst = 1'b1;
        cmp_en = 1'b1;

        // step mode: MOV A,5; ADD A,12; MOV B,A; OUT B
        rom[0] = 8'b0011_0101;
        rom[1] = 8'b0000_1100;
        rom[2] = 8'b0100_0000;
        rom[3] = 8'b1001_0000;
        rom[4] = 8'b0011_0111;
        release_reset();
        check("reset_addr", int'(addr), 0);
        done_seen = 0;
        do_step();
        do_step();
        check("step2_carry", int'(carry), 1);
        do_step();
        check("step3_carry", int'(carry), 0);
        do_step();
        check("step4_out", int'(out_port), 1);
        check("step4_addr", int'(addr), 4);
        check("step_done_count", done_seen, 4);

        // reset while the fifth instruction is in EXEC
        step = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_addr",  int'(addr),     0);
        check("async_rst_out",   int'(out_port), 0);
        check("async_rst_carry", int'(carry),    0);
        check("async_rst_done",  int'(done),     0);
        step = 1'b0;
        release_reset();
        check("abandoned_out", int'(out_port), 0);

        // run mode: count A up until carry, then OUT 10
        hold_reset();
        clear_rom();
        rom[0] = 8'b0000_0001;
        rom[1] = 8'b1110_0000;
        rom[2] = 8'b1011_1010;
        rom[3] = 8'b1111_0011;
        release_reset();
        run = 1'b1;
        cnt = 0;
        k   = 0;
        while (out_port != 4'd10 && k < 400) begin
            @(negedge clk);
            k++;
            if (done) cnt++;
        end
        check("run_out", int'(out_port), 10);
        check("run_retired", cnt, 33);
        k = 0;
        while (!done && k < 20) begin @(negedge clk); k++; end
        k = 0;
        do begin @(negedge clk); k++; end while (!done && k < 20);
        check("run_spacing", k, 4);
        k = 0;
        do begin @(negedge clk); k++; end while (!done && k < 20);
        check("run_spacing2", k, 4);
        run = 1'b0;
        repeat (20) @(negedge clk);

        // PC wrap with no jumps
        hold_reset();
        for (int i = 0; i < PMOD; i++) rom[i] = {4'b0111, 4'(i)};
        release_reset();
        run = 1'b1;
        cnt = 0;
        k   = 0;
        while (cnt < 16 && k < 200) begin
            @(negedge clk);
            k++;
            if (done) begin
                cnt++;
                if (cnt == 15) check("wrap_pre", int'(addr), 15);
                if (cnt == 16) check("wrap_post", int'(addr), 0);
            end
        end
        check("wrap_count", cnt, 16);
        run = 1'b0;
        repeat (20) @(negedge clk);

        // IN ports and unassigned opcodes
        hold_reset();
        clear_rom();
        in_port = 4'hA;
        rom[0] = 8'b0010_0000;
        rom[1] = 8'b0100_0000;
        rom[2] = 8'b1001_0000;
        rom[3] = 8'b0000_1111;
        rom[4] = 8'b1000_0000;
        rom[5] = 8'b1010_0000;
        rom[6] = 8'b1100_0000;
        rom[7] = 8'b1101_0000;
        rom[8] = 8'b0110_0000;
        rom[9] = 8'b1001_0000;
        release_reset();
        do_step();
        do_step();
        do_step();
        check("in_a_out", int'(out_port), 10);
        do_step();
        check("add15_carry", int'(carry), 1);
        do_step();
        check("ill_at_done", ill_at_done, 1);
        check("ill_done_next", done_next, 0);
        check("ill_next", ill_next, 0);
        check("ill_addr", int'(addr), 5);
        check("ill_carry", int'(carry), 0);
        do_step();
        do_step();
        do_step();
        in_port = 4'h5;
        do_step();
        do_step();
        check("in_b_out", int'(out_port), 5);

        // second STEP edge reaches the sequencer while the first is in flight
        hold_reset();
        clear_rom();
        rom[0] = 8'b0011_0001;
        release_reset();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        step = 1'b1;
        cnt = 0;
        repeat (15) begin @(negedge clk); if (done) cnt++; end
        step = 1'b0;
        repeat (5) begin @(negedge clk); if (done) cnt++; end
        check("drop_done_count", cnt, 1);
        check("drop_addr", int'(addr), 1);

        k = 0;
        while (!dut8_fin && k < 100) begin @(negedge clk); k++; end
        check("dw8_finished", int'(dut8_fin), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // DW=8 instance: JMP 0x13 truncates to 3, OUT 0xC5, park on JMP 0x14 -> 4
    initial begin
        int k;
        for (int i = 0; i < 16; i++) rom8[i] = '0;
        rom8[0] = {4'b1111, 8'h13};
        rom8[3] = {4'b1011, 8'hC5};
        rom8[4] = {4'b1111, 8'h14};
        run8 = 1'b1;
        #1 rst8 = 1'b1;
        #20 rst8 = 1'b0;
        k = 0;
        while (!done8 && k < 40) begin @(negedge clk); k++; end
        check("dw8_jmp_trunc", int'(addr8), 3);
        @(negedge clk);
        k = 0;
        while (!done8 && k < 40) begin @(negedge clk); k++; end
        check("dw8_out", int'(out8), 197);
        check("dw8_park", int'(addr8), 4);
        dut8_fin = 1'b1;
    end

endmodule
